// File: rtl/mid_pool_reader.sv
// Mid-layer row-pair reader with 2x2 signed max-pooling over three channels.
// Optional: define MID_POOL_RELU_EN to clamp negative pooled results to zero.

module mid_pool_lane #(
  parameter int DW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] top_i,
  input  logic [DW-1:0] bot_i,
  input  logic          v_en_i,
  input  logic          hold_en_i,
  input  logic          out_en_i,
  output logic [DW-1:0] pool_o
);
  logic signed [DW-1:0] vmax_d, vmax_q, hold_q, hmax, pool_d, pool_q;

  assign vmax_d = ($signed(top_i) >= $signed(bot_i)) ? $signed(top_i) : $signed(bot_i);
  assign hmax   = (hold_q >= vmax_q) ? hold_q : vmax_q;
`ifdef MID_POOL_RELU_EN
  assign pool_d = hmax[DW-1] ? '0 : hmax;
`else
  assign pool_d = hmax;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vmax_q <= '0;
      hold_q <= '0;
      pool_q <= '0;
    end else begin
      if (v_en_i)    vmax_q <= vmax_d;
      if (hold_en_i) hold_q <= vmax_q;
      if (out_en_i)  pool_q <= pool_d;
    end
  end

  assign pool_o = pool_q;
endmodule

module mid_pool_reader #(
  parameter logic [10:0] image_width  = 11'd28,
  parameter logic [10:0] image_height = 11'd28
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        fin_rd,
  input  logic        bram_toggle,
  input  logic [20:0] qa_0, qa_1, qa_2, qa_3,
  input  logic [20:0] qb_0, qb_1, qb_2, qb_3,
  input  logic [20:0] qc_0, qc_1, qc_2, qc_3,
  output logic        in0_rden,
  output logic        in1_rden,
  output logic        in2_rden,
  output logic        in3_rden,
  output logic [10:0] rd_addr,
  output logic [20:0] pool_a,
  output logic [20:0] pool_b,
  output logic [20:0] pool_c,
  output logic        de_out,
  output logic        row_done,
  output logic        frame_done,
  output logic        overrun
);
  localparam int NUM_LANES = 3;
  localparam int DW        = 21;
  localparam int STAGES    = 2;
  localparam logic [10:0] LAST_COL = image_width - 11'd1;
  localparam logic [10:0] LAST_ROW = image_height / 11'd2 - 11'd1;

  typedef enum logic [1:0] {IDLE, ARM, READ, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;
  logic [1:0]  drain_q, drain_d;
  logic        sel_q, sel_d;
  logic        row_done_d, row_done_q, frame_done_q, overrun_q, de_q;
  logic [10:0] row_cnt_q;
  logic        rd_en;
  logic [STAGES:1] vld_pipe_q, odd_pipe_q;
  logic        hold_en, out_en;
  logic [NUM_LANES-1:0][DW-1:0] top, bot, pool;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    drain_d    = drain_q;
    sel_d      = sel_q;
    row_done_d = 1'b0;
    case (state_q)
      IDLE:  if (fin_rd) state_d = ARM;
      ARM: begin
        sel_d   = bram_toggle;
        col_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      DRAIN: begin
        // Three drain cycles cover the BRAM, vertical and horizontal stages.
        if (drain_q == 2'd2) begin
          row_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      col_q        <= '0;
      drain_q      <= '0;
      sel_q        <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      row_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      vld_pipe_q   <= '0;
      odd_pipe_q   <= '0;
      de_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      drain_q      <= drain_d;
      sel_q        <= sel_d;
      row_done_q   <= row_done_d;
      frame_done_q <= row_done_d && (row_cnt_q == LAST_ROW);
      if (row_done_d) row_cnt_q <= (row_cnt_q == LAST_ROW) ? 11'd0 : row_cnt_q + 11'd1;
      if (fin_rd && state_q != IDLE) overrun_q <= 1'b1;
      vld_pipe_q   <= {vld_pipe_q[1], rd_en};
      odd_pipe_q   <= {odd_pipe_q[1], col_q[0]};
      de_q         <= out_en;
    end
  end

  assign rd_en    = (state_q == READ);
  assign in0_rden = rd_en & sel_q;
  assign in1_rden = rd_en & sel_q;
  assign in2_rden = rd_en & ~sel_q;
  assign in3_rden = rd_en & ~sel_q;
  assign rd_addr  = rd_en ? col_q : 11'd0;

  // Even column results are held; a trailing even column on odd widths is simply never paired.
  assign hold_en = vld_pipe_q[2] & ~odd_pipe_q[2];
  assign out_en  = vld_pipe_q[2] &  odd_pipe_q[2];

  assign top[0] = sel_q ? qa_0 : qa_2;
  assign bot[0] = sel_q ? qa_1 : qa_3;
  assign top[1] = sel_q ? qb_0 : qb_2;
  assign bot[1] = sel_q ? qb_1 : qb_3;
  assign top[2] = sel_q ? qc_0 : qc_2;
  assign bot[2] = sel_q ? qc_1 : qc_3;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mid_pool_lane #(.DW(DW)) u_lane (
      .clk      (clk),
      .rst      (RESET),
      .top_i    (top[l]),
      .bot_i    (bot[l]),
      .v_en_i   (vld_pipe_q[1]),
      .hold_en_i(hold_en),
      .out_en_i (out_en),
      .pool_o   (pool[l])
    );
  end

  assign pool_a     = pool[0];
  assign pool_b     = pool[1];
  assign pool_c     = pool[2];
  assign de_out     = de_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_mid_pool_reader.sv
// Directed bench for mid_pool_reader: table of 2x2 windows plus row/frame/overrun/abort sequences.
module tb_mid_pool_reader;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic fin_rd = 1'b0;
  logic bram_toggle = 1'b0;
  logic [20:0] q [3][4];
  logic signed [20:0] mem [3][4][28];
  logic in0_rden, in1_rden, in2_rden, in3_rden;
  logic [10:0] rd_addr;
  logic [20:0] pool_a, pool_b, pool_c;
  logic de_out, row_done, frame_done, overrun;

  mid_pool_reader dut (
    .clk(clk), .RESET(RESET), .fin_rd(fin_rd), .bram_toggle(bram_toggle),
    .qa_0(q[0][0]), .qa_1(q[0][1]), .qa_2(q[0][2]), .qa_3(q[0][3]),
    .qb_0(q[1][0]), .qb_1(q[1][1]), .qb_2(q[1][2]), .qb_3(q[1][3]),
    .qc_0(q[2][0]), .qc_1(q[2][1]), .qc_2(q[2][2]), .qc_3(q[2][3]),
    .in0_rden(in0_rden), .in1_rden(in1_rden), .in2_rden(in2_rden), .in3_rden(in3_rden),
    .rd_addr(rd_addr), .pool_a(pool_a), .pool_b(pool_b), .pool_c(pool_c),
    .de_out(de_out), .row_done(row_done), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered BRAM model, one-cycle read latency.
  logic [3:0] rden;
  assign rden = {in3_rden, in2_rden, in1_rden, in0_rden};
  always @(posedge clk)
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 4; b++)
        if (rden[b] && rd_addr < 11'd28) q[c][b] <= mem[c][b][rd_addr[4:0]];

  // Monitor: cumulative counters, never written elsewhere.
  logic signed [20:0] qa[$], qb[$], qc[$];
  int qcyc[$], rdq[$];
  int fin_cyc = 0;
  int de_twice = 0, fr_cnt = 0, fr_err = 0, r01 = 0, r23 = 0, pair_err = 0, addr_err = 0, de_tot = 0;
  logic de_prev = 1'b0;
  always @(negedge clk) begin
    if (de_out) begin
      qa.push_back(pool_a); qb.push_back(pool_b); qc.push_back(pool_c); qcyc.push_back(cyc);
    end
    if (de_out) de_tot <= de_tot + 1;
    if (de_out && de_prev) de_twice <= de_twice + 1;
    de_prev <= de_out;
    if (row_done) rdq.push_back(cyc);
    if (frame_done) fr_cnt <= fr_cnt + 1;
    if (frame_done && !row_done) fr_err <= fr_err + 1;
    if (in0_rden && in1_rden) r01 <= r01 + 1;
    if (in2_rden && in3_rden) r23 <= r23 + 1;
    if ((in0_rden ^ in1_rden) || (in2_rden ^ in3_rden) || (in0_rden && in2_rden)) pair_err <= pair_err + 1;
    if (|rden) begin
      if (rd_addr != 11'(cyc - fin_cyc - 2)) addr_err <= addr_err + 1;
    end else if (rd_addr != 11'd0) addr_err <= addr_err + 1;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ex(input int v);
`ifdef MID_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  int ob, rb, r01b, r23b, ab, pb, dtb, fb;

  task automatic fill_all(input int v);
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 28; k++) mem[c][b][k] = 21'(v);
  endtask

  // a/c: top=col, bottom=100+col; b: bitwise inverse. Unselected pair holds a sentinel.
  task automatic fill_ramp(input bit tog);
    int t, u;
    fill_all(1000000);
    t = tog ? 0 : 2; u = tog ? 1 : 3;
    for (int k = 0; k < 28; k++) begin
      mem[0][t][k] = 21'(k);  mem[0][u][k] = 21'(100 + k);
      mem[2][t][k] = 21'(k);  mem[2][u][k] = 21'(100 + k);
      mem[1][t][k] = ~21'(k); mem[1][u][k] = ~21'(100 + k);
    end
  endtask

  task automatic run_row(input int extra_at);
    bit done;
    done = 0;
    ob = qa.size(); rb = rdq.size(); r01b = r01; r23b = r23;
    ab = addr_err; pb = pair_err; dtb = de_twice; fb = fr_cnt;
    @(posedge clk); #1;
    fin_cyc = cyc; fin_rd = 1'b1;
    for (int i = 1; i < 80 && !done; i++) begin
      @(posedge clk); #1;
      fin_rd = (i == extra_at);
      if (rdq.size() > rb) done = 1;
    end
    fin_rd = 1'b0;
    chk("row_timeout", int'(done), 1);
  endtask

  task automatic check_ramp(input bit tog);
    int bad, n;
    bad = 0;
    n = qa.size() - ob;
    chk("n_out", n, 14);
    for (int k = 0; k < 14 && k < n; k++)
      if (int'(qa[ob+k]) != ex(101 + 2*k) || int'(qb[ob+k]) != ex(-2*k - 1) ||
          int'(qc[ob+k]) != ex(101 + 2*k) || qcyc[ob+k] - fin_cyc != 6 + 2*k) bad++;
    chk("pool_vals", bad, 0);
    chk("first_lat", (n > 0) ? qcyc[ob] - fin_cyc : -1, 6);
    chk("row_done_lat", (rdq.size() > rb) ? rdq[rb] - fin_cyc : -1, 33);
    chk("rden_sel", tog ? r01 - r01b : r23 - r23b, 28);
    chk("rden_unsel", tog ? r23 - r23b : r01 - r01b, 0);
    chk("rd_addr_seq", addr_err - ab, 0);
    chk("rden_pair", pair_err - pb, 0);
    chk("de_back2back", de_twice - dtb, 0);
  endtask

  typedef struct {
    bit tog;
    int t0, t1, b0, b1;
    int expa, expb;
  } vec_t;
  vec_t vt[5];

  initial begin
    int n0, de0, rd0;
    vt[0] = '{1'b1, 5, 3, 2, 9, 9, -3};
    vt[1] = '{1'b0, -5, -1, -3, -7, -1, 6};
    vt[2] = '{1'b1, 7, 7, 7, 7, 7, -8};
    vt[3] = '{1'b0, 1048575, -1048576, -1, 0, 1048575, 1048575};
    vt[4] = '{1'b1, -1048576, -1048576, -1048576, -1048576, -1048576, 1048575};
    fill_all(0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", int'(rden), 0);
    chk("rst_pool_a", int'(pool_a), 0);
    #1 RESET = 1'b0;
    @(negedge clk);
    chk("rst_addr", int'(rd_addr), 0);
    chk("rst_flags", int'({de_out, row_done, frame_done, overrun}), 0);
    chk("rst_pools", int'(pool_b | pool_c), 0);

    // Table of single 2x2 windows in columns 0/1; remaining columns are zero.
    for (int v = 0; v < 5; v++) begin
      int t, u;
      fill_all(1000000);
      t = vt[v].tog ? 0 : 2; u = vt[v].tog ? 1 : 3;
      for (int k = 0; k < 28; k++) begin
        for (int c = 0; c < 3; c++) begin mem[c][t][k] = '0; mem[c][u][k] = '0; end
      end
      mem[0][t][0] = 21'(vt[v].t0); mem[0][t][1] = 21'(vt[v].t1);
      mem[0][u][0] = 21'(vt[v].b0); mem[0][u][1] = 21'(vt[v].b1);
      for (int k = 0; k < 2; k++) begin
        mem[2][t][k] = mem[0][t][k]; mem[2][u][k] = mem[0][u][k];
        mem[1][t][k] = ~mem[0][t][k]; mem[1][u][k] = ~mem[0][u][k];
      end
      bram_toggle = vt[v].tog;
      run_row(0);
      chk($sformatf("vec%0d_n", v), qa.size() - ob, 14);
      if (qa.size() > ob + 1) begin
        chk($sformatf("vec%0d_a", v), int'(qa[ob]), ex(vt[v].expa));
        chk($sformatf("vec%0d_b", v), int'(qb[ob]), ex(vt[v].expb));
        chk($sformatf("vec%0d_c", v), int'(qc[ob]), ex(vt[v].expa));
        chk($sformatf("vec%0d_next", v), int'(qa[ob+1]), 0);
      end
    end

    // Full ramp rows on both bank pairs
    fill_ramp(1'b1); bram_toggle = 1'b1; run_row(0); check_ramp(1'b1);
    fill_ramp(1'b0); bram_toggle = 1'b0; run_row(0); check_ramp(1'b0);
    chk("no_overrun", int'(overrun), 0);

    // fin_rd during READ: row unaffected, overrun sticky
    fill_ramp(1'b1); bram_toggle = 1'b1; run_row(10); check_ramp(1'b1);
    chk("overrun_set", int'(overrun), 1);
    run_row(0);
    chk("overrun_sticky", int'(overrun), 1);

    // RESET at column 10 aborts the row
    @(posedge clk); #1;
    fin_cyc = cyc; fin_rd = 1'b1;
    @(posedge clk); #1;
    fin_rd = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    chk("abort_at_col10", int'(rd_addr), 10);
    RESET = 1'b1; #1;
    chk("abort_de", int'(de_out), 0);
    chk("abort_rden", int'(rden), 0);
    chk("abort_overrun", int'(overrun), 0);
    @(posedge clk); #1 RESET = 1'b0;
    de0 = de_tot; rd0 = rdq.size();
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_de", de_tot - de0, 0);
    chk("abort_no_row_done", rdq.size() - rd0, 0);
    run_row(0); check_ramp(1'b1);

    // Frame: frame_done on every 14th row since reset, counter wraps
    RESET = 1'b1;
    @(posedge clk); #1 RESET = 1'b0;
    n0 = 0;
    for (int r = 1; r <= 28; r++) begin
      run_row(0);
      chk($sformatf("frame_row%0d", r), fr_cnt - fb, (r % 14 == 0) ? 1 : 0);
      if (r == 14 || r == 28) check_ramp(1'b1);
    end
    chk("frame_with_row_done", fr_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mid_pool_reader.md
# mid_pool_reader

Reads the completed row pairs out of the mid-layer row buffer's four 21-bit BRAM banks and performs 2x2 signed max-pooling on the three channels (a, b, c). It sits directly downstream of the row buffer, which signals each finished pair with `fin_rd` and selects the pair with `bram_toggle`. For each row pair it drives the bank read enables and read address, then emits one pooled pixel per channel for every two columns to the next layer.

## Interface
Parameters:
- `image_width`, 11'd28: columns per row (read-address sweep length).
- `image_height`, 11'd28: rows per frame; the block produces `image_height/2` pooled rows per frame.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `fin_rd`  in  1  one-cycle pulse: a row pair is complete in the buffer.
- `bram_toggle`  in  1  bank-pair select from the buffer.
- `qa_0..qa_3`, `qb_0..qb_3`, `qc_0..qc_3`  in  21 each  bank read data; registered, 1-cycle latency after rden/addr.
- `in0_rden`, `in1_rden`, `in2_rden`, `in3_rden`  out  1  bank read enables.
- `rd_addr`  out  11  shared bank read address.
- `pool_a`, `pool_b`, `pool_c`  out  21  pooled pixels, signed two's complement.
- `de_out`  out  1  pooled pixel valid.
- `row_done`  out  1  one-cycle pulse after the last pooled pixel of a row.
- `frame_done`  out  1  one-cycle pulse together with the final `row_done` of a frame.
- `overrun`  out  1  sticky: `fin_rd` arrived while the block was busy.

## Operation
- FSM states: IDLE, ARM, READ, DRAIN.
- IDLE: on `fin_rd`=1, go to ARM.
- ARM, one cycle: latch `sel` = `bram_toggle`.
  - `sel`=1 reads banks 0 (top row) and 1 (bottom row).
  - `sel`=0 reads banks 2 (top row) and 3 (bottom row).
  - Go to READ with the column counter at 0.
- READ:
  - Assert the two selected rden signals and set `rd_addr` = column counter.
  - Increment the counter each cycle through 0..`image_width`-1.
  - After the last column, go to DRAIN.
- DRAIN: wait 3 cycles for the pipeline to empty, pulse `row_done`, return to IDLE.
- Pipeline:
  - Stage 1 (BRAM): q valid 1 cycle after the address.
  - Stage 2: vertical signed max per channel, max(top, bottom), registered.
  - Stage 3: on odd columns, horizontal signed max of the held even-column result and the current result, registered to `pool_*` with `de_out`=1.
- Odd `image_width`: the last column is read and discarded; the output count per row is floor(`image_width`/2).
- Pooled-row counter: counts 0..`image_height`/2-1 and increments on `row_done`. At the last count it also pulses `frame_done` and wraps to 0.
- `fin_rd` in any state other than IDLE is ignored and sets `overrun` until RESET.
- All rden signals not selected stay 0. `rd_addr` is 0 when not in READ.

## Timing
- Reset values: all rden=0, `rd_addr`=0, `pool_*`=0, `de_out`=0, `row_done`=0, `frame_done`=0, `overrun`=0, FSM=IDLE, counters=0.
- Cycle n: `fin_rd`. Cycle n+1: ARM. Cycles n+2 .. n+1+`image_width`: READ.
- Column c is addressed at cycle n+2+c.
- The pooled pixel k (columns 2k, 2k+1) has `de_out`=1 at cycle n+2+(2k+1)+3, i.e. 3 cycles after the odd column's address.
- `de_out` pulses every other cycle and is never high two cycles in a row.
- `row_done` asserts at cycle n+2+`image_width`+3. The block is back in IDLE and accepts `fin_rd` the following cycle.
- RESET asserted mid-row aborts the row: return to IDLE immediately and clear all outputs and counters. There is no partial `row_done`.
- Arithmetic: signed 21-bit compare; no width growth. Ties return the equal value.

## Configuration
- `MID_POOL_RELU_EN` defined: stage 3 clamps negative results to 0 before registering `pool_*` (ReLU fused after pooling).
- Not defined: `pool_*` carries the signed max unchanged, including negative values.

## Test plan
- Reset state: RESET high, then low → all outputs 0, FSM IDLE.
- `bram_toggle`=1, top row = 0..27, bottom row = 100..127, `fin_rd` pulse → `in0_rden`/`in1_rden` high for 28 cycles; 14 outputs, `pool_a` = 101, 103, …, 127, first one 6 cycles after `fin_rd`; `row_done` at `fin_rd`+33.
- `bram_toggle`=0, a negative mix in banks 2/3 (top = -5, -1; bottom = -3, -7) → `pool` = -1 without the macro, 0 with `MID_POOL_RELU_EN`.
- 14 consecutive row pairs → `frame_done` coincides with the 14th `row_done`; the row counter wraps to 0.
- `fin_rd` pulsed during READ → output is unaffected and `overrun` goes to 1 and stays set.
- RESET pulsed at column 10 → `de_out` stops immediately, no `row_done`; the next `fin_rd` produces a clean full row.
